// File: rtl/button_conditioner_if.sv
// Button-panel bundle: raw push-buttons in, debounced levels and event pulses out.
interface button_conditioner_if;
  logic       btn_ctr, btn_rgt, btn_lft, btn_up, btn_dn;
  logic       ctr_p, rgt_p, lft_p, up_p, dn_p;
  logic [4:0] level;

  modport master (
    output btn_ctr, btn_rgt, btn_lft, btn_up, btn_dn,
    input  ctr_p, rgt_p, lft_p, up_p, dn_p, level
  );

  modport slave (
    input  btn_ctr, btn_rgt, btn_lft, btn_up, btn_dn,
    output ctr_p, rgt_p, lft_p, up_p, dn_p, level
  );
endinterface

// File: rtl/button_conditioner.sv
// Five-channel push-button conditioner: sync, debounce, press pulses, and
// hold-to-repeat on up/dn with mutual lockout while both are held.

module bc_channel #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_press
);
  localparam logic [31:0] DEB_TERM = 32'(DEBOUNCE_CYCLES - 1);

  logic [1:0]  r_sync;
  logic [31:0] r_cnt;
  logic        r_level;
  logic        r_press;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_raw};
      r_press <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == DEB_TERM) begin
        // pulse only on the 0->1 transition, same cycle the level rises
        r_cnt   <= '0;
        r_level <= ~r_level;
        r_press <= ~r_level;
      end else begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;
endmodule

module bc_repeat #(
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_press,
  input  logic i_level,
  input  logic i_lock,
  output logic o_pulse
);
  localparam logic [31:0] DLY_TERM = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] PER_TERM = 32'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_cnt, w_cnt_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_pulse     = 1'b0;
    // release or up+dn lockout parks the FSM; only a fresh press re-arms it
    if (!i_level || i_lock) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: if (i_press) begin
          w_state_nxt = DELAY;
          w_cnt_nxt   = '0;
        end
        DELAY: if (r_cnt == DLY_TERM) begin
          o_pulse     = 1'b1;
          w_state_nxt = REPEAT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
        REPEAT: if (r_cnt == PER_TERM) begin
          o_pulse   = 1'b1;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end
endmodule

module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 25_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  button_conditioner_if.slave bus
);
  localparam int NUM_LANES = 5;

  logic [NUM_LANES-1:0] w_raw, w_level, w_press, w_pulse;
  logic [1:0]           w_rpt;
  logic                 w_lock;

  assign w_raw  = {bus.btn_dn, bus.btn_up, bus.btn_lft, bus.btn_rgt, bus.btn_ctr};
  assign w_lock = w_level[3] & w_level[4];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    bc_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_raw   (w_raw[g]),
      .o_level (w_level[g]),
      .o_press (w_press[g])
    );
  end

  for (genvar g = 0; g < 2; g++) begin : g_rpt
    bc_repeat #(
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_rpt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_press (w_press[3+g]),
      .i_level (w_level[3+g]),
      .i_lock  (w_lock),
      .o_pulse (w_rpt[g])
    );
  end

  // gate with rst_n so nothing escapes during the reset cycle itself
  assign w_pulse   = (w_press | {w_rpt, 3'b000}) & {NUM_LANES{rst_n}};
  assign bus.ctr_p = w_pulse[0];
  assign bus.rgt_p = w_pulse[1];
  assign bus.lft_p = w_pulse[2];
  assign bus.up_p  = w_pulse[3];
  assign bus.dn_p  = w_pulse[4];
  assign bus.level = w_level;
endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench: expected pulse events are queued per cycle and compared
// against all five pulse outputs every cycle.
module tb_button_conditioner;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  typedef struct {
    int         cyc;
    logic [4:0] m;
  } ev_t;
  ev_t q[$];

  button_conditioner_if bus ();

  button_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void add(int c, logic [4:0] m);
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].cyc == c) begin
        q[i].m = q[i].m | m;
        return;
      end
      if (q[i].cyc > c) begin
        q.insert(i, '{c, m});
        return;
      end
    end
    q.push_back('{c, m});
  endfunction

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [4:0] act, expv;
  always @(negedge clk) begin
    act  = {bus.dn_p, bus.up_p, bus.lft_p, bus.rgt_p, bus.ctr_p};
    expv = 5'b0;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      bad++;
      $error("FAIL stale_event cyc=%0d observed=none expected=%b", q[0].cyc, q[0].m);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      expv = q[0].m;
      void'(q.pop_front());
    end
    total++;
    assert (act === expv) else begin
      bad++;
      $error("FAIL pulses cyc=%0d observed=%b expected=%b", cyc, act, expv);
    end
  end

  initial begin
    int c, p, r, s;
    logic [5:0] pat;
    rst_n = 1'b0;
    bus.btn_ctr = 1'b0; bus.btn_rgt = 1'b0; bus.btn_lft = 1'b0;
    bus.btn_up  = 1'b0; bus.btn_dn  = 1'b0;
    step(3);
    chk("reset_level", 32'(bus.level), 32'h0);
    rst_n = 1'b1;
    step(2);

    // clean ctr press, 20 cycles
    c = cyc; bus.btn_ctr = 1'b1; add(c + 6, 5'b00001);
    step(5); chk("ctr_level_pre", 32'(bus.level), 32'h0);
    step(1); chk("ctr_level", 32'(bus.level), 32'h01);
    step(14); bus.btn_ctr = 1'b0;
    step(5); chk("ctr_level_hold", 32'(bus.level), 32'h01);
    step(1); chk("ctr_level_fall", 32'(bus.level), 32'h0);
    step(4);

    // lft bounce 1,0,1,1,0,1 then stable 1
    pat = 6'b101101;
    for (int i = 0; i < 6; i++) begin
      bus.btn_lft = pat[i];
      if (i < 5) step(1);
    end
    s = cyc; add(s + 6, 5'b00100);
    step(5); chk("lft_level_pre", 32'(bus.level), 32'h0);
    step(1); chk("lft_level", 32'(bus.level), 32'h04);
    step(2); bus.btn_lft = 1'b0;
    step(8);

    // up held: press then 4 repeats
    c = cyc; p = c + 6; bus.btn_up = 1'b1;
    add(p, 5'b01000); add(p + 10, 5'b01000); add(p + 15, 5'b01000);
    add(p + 20, 5'b01000); add(p + 25, 5'b01000);
    step(30); bus.btn_up = 1'b0;
    step(12);

    // up repeating, dn pressed: lockout, no resume after dn release
    c = cyc; p = c + 6; bus.btn_up = 1'b1;
    add(p, 5'b01000); add(p + 10, 5'b01000); add(p + 15, 5'b01000);
    add(p + 20, 5'b01000); add(p + 22, 5'b10000);
    step(22); bus.btn_dn = 1'b1;
    step(12); chk("lock_level", 32'(bus.level), 32'h18);
    bus.btn_dn = 1'b0;
    step(22); chk("lock_up_only", 32'(bus.level), 32'h08);
    bus.btn_up = 1'b0;
    step(10);
    c = cyc; bus.btn_up = 1'b1;
    add(c + 6, 5'b01000); add(c + 16, 5'b01000);
    step(13); bus.btn_up = 1'b0;
    step(10);

    // reset during up DELAY with button held
    c = cyc; p = c + 6; bus.btn_up = 1'b1; add(p, 5'b01000);
    step(11); r = cyc; rst_n = 1'b0;
    add(r + 7, 5'b01000); add(r + 17, 5'b01000); add(r + 22, 5'b01000);
    step(1); rst_n = 1'b1;
    chk("rst_level", 32'(bus.level), 32'h0);
    step(18); bus.btn_up = 1'b0;
    step(12);

    // all five on the same edge
    c = cyc;
    bus.btn_ctr = 1'b1; bus.btn_rgt = 1'b1; bus.btn_lft = 1'b1;
    bus.btn_up  = 1'b1; bus.btn_dn  = 1'b1;
    add(c + 6, 5'b11111);
    step(6); chk("all_level", 32'(bus.level), 32'h1F);
    step(20);
    bus.btn_ctr = 1'b0; bus.btn_rgt = 1'b0; bus.btn_lft = 1'b0;
    bus.btn_up  = 1'b0; bus.btn_dn  = 1'b0;
    step(10);
    chk("all_level_off", 32'(bus.level), 32'h0);
    chk("queue_drained", 32'(q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
